// File: rtl/fft_unload_if.sv
// Output stream interface of the FFT result reader.
// One complex bin per transfer; a word moves when oVALID & iREADY.
//   oDATA_RE / oDATA_IM : bin value (DATA_W each)
//   oINDEX              : bin number of the word on the bus
//   oLAST               : high with bin 2047
//   oVALID / iREADY     : handshake
// master = fft_unload, slave = host / DMA side.
interface fft_unload_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] oDATA_RE;
  logic [DATA_W-1:0] oDATA_IM;
  logic [10:0]       oINDEX;
  logic              oVALID;
  logic              oLAST;
  logic              iREADY;

  modport master (
    output oDATA_RE, oDATA_IM, oINDEX, oVALID, oLAST,
    input  iREADY
  );

  modport slave (
    input  oDATA_RE, oDATA_IM, oINDEX, oVALID, oLAST,
    output iREADY
  );
endinterface

// File: rtl/fft_unload.sv
// fft_unload: result reader for the 2048-point FFT core.
// On iSTART it reads all 2048 bins out of the 4 bank RAMs (A/B set chosen by
// iSOURCE_DATA) and streams them through a small FIFO to the output interface.
// Ports:
//   iCLK, iRESET (async, active low)
//   iSTART, iSOURCE_DATA         : begin unload / result RAM set
//   oRAM_SEL, oBANK_SEL,
//   oADDR_RD, oRD_EN             : bank RAM read port (data valid 1 cycle later)
//   iRD_RE_0..3, iRD_IM_0..3     : bank read data
//   out_if (fft_unload_if.master): oDATA_RE/IM, oINDEX, oVALID, oLAST, iREADY
//   oBUSY                        : unload in progress
// Build option: define UNLOAD_DIGIT_REV_EN to emit bins in natural order
// (mixed radix-4^5 x 2 digit reversal of the read address); otherwise bins
// come out in storage order.
module fft_unload #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FIFO_D = 4
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic              iSOURCE_DATA,
  output logic              oRAM_SEL,
  output logic [1:0]        oBANK_SEL,
  output logic [8:0]        oADDR_RD,
  output logic              oRD_EN,
  input  logic [DATA_W-1:0] iRD_RE_0,
  input  logic [DATA_W-1:0] iRD_RE_1,
  input  logic [DATA_W-1:0] iRD_RE_2,
  input  logic [DATA_W-1:0] iRD_RE_3,
  input  logic [DATA_W-1:0] iRD_IM_0,
  input  logic [DATA_W-1:0] iRD_IM_1,
  input  logic [DATA_W-1:0] iRD_IM_2,
  input  logic [DATA_W-1:0] iRD_IM_3,
  fft_unload_if.master      out_if,
  output logic              oBUSY
);

  localparam int unsigned PW = $clog2(FIFO_D);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_D);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  function automatic logic [10:0] storage_idx(input logic [10:0] n);
`ifdef UNLOAD_DIGIT_REV_EN
    return {n[1:0], n[3:2], n[5:4], n[7:6], n[9:8], n[10]};
`else
    return n;
`endif
  endfunction

  state_t            state_q, state_d;
  logic              ram_sel_q, ram_sel_d;
  logic [1:0]        bank_q, bank_d;
  logic [8:0]        addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic [10:0]       rd_idx_q, rd_idx_d;
  logic [10:0]       rd_cnt_q, rd_cnt_d;
  logic              busy_q, busy_d;
  logic              wr_v_q, wr_v_d;
  logic [1:0]        wr_lane_q, wr_lane_d;
  logic [10:0]       wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] fifo_re_q [FIFO_D];
  logic [DATA_W-1:0] fifo_re_d [FIFO_D];
  logic [DATA_W-1:0] fifo_im_q [FIFO_D];
  logic [DATA_W-1:0] fifo_im_d [FIFO_D];
  logic [10:0]       fifo_idx_q [FIFO_D];
  logic [10:0]       fifo_idx_d [FIFO_D];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;

  logic              issue, push, pop;
  logic [10:0]       n_sel, s_idx;
  logic [CW:0]       outstanding;
  logic [DATA_W-1:0] lane_re, lane_im;

  always_comb begin
    state_d    = state_q;
    ram_sel_d  = ram_sel_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    rd_idx_d   = rd_idx_q;
    rd_cnt_d   = rd_cnt_q;
    busy_d     = busy_q;
    fifo_re_d  = fifo_re_q;
    fifo_im_d  = fifo_im_q;
    fifo_idx_d = fifo_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    issue      = 1'b0;
    n_sel      = rd_cnt_q;
    s_idx      = '0;

    // Data from the read strobed last cycle is on the bank bus now.
    wr_v_d    = rd_en_q;
    wr_lane_d = bank_q;
    wr_idx_d  = rd_idx_q;
    push      = wr_v_q;
    pop       = (fifo_cnt_q != '0) && out_if.iREADY;

    unique case (wr_lane_q)
      2'd0:    begin lane_re = iRD_RE_0; lane_im = iRD_IM_0; end
      2'd1:    begin lane_re = iRD_RE_1; lane_im = iRD_IM_1; end
      2'd2:    begin lane_re = iRD_RE_2; lane_im = iRD_IM_2; end
      default: begin lane_re = iRD_RE_3; lane_im = iRD_IM_3; end
    endcase

    if (push) begin
      fifo_re_d[wr_ptr_q]  = lane_re;
      fifo_im_d[wr_ptr_q]  = lane_im;
      fifo_idx_d[wr_ptr_q] = wr_idx_q;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // The read decision is made one cycle ahead of the registered strobe, so
    // both the strobed read and the one being captured still owe a FIFO slot.
    outstanding = {1'b0, fifo_cnt_q} + {{CW{1'b0}}, rd_en_q} + {{CW{1'b0}}, wr_v_q};

    unique case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          // First read (index 0) is issued straight from IDLE so that the
          // strobe appears in the cycle right after iSTART.
          issue     = 1'b1;
          n_sel     = '0;
          ram_sel_d = iSOURCE_DATA;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (outstanding < DEPTH) begin
          issue = 1'b1;
          if (rd_cnt_q == 11'h7FF) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!rd_en_q && !wr_v_q && (fifo_cnt_d == '0)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      s_idx    = storage_idx(n_sel);
      bank_d   = s_idx[10:9];
      addr_d   = s_idx[8:0];
      rd_en_d  = 1'b1;
      rd_idx_d = n_sel;
      rd_cnt_d = n_sel + 11'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q    <= ST_IDLE;
      ram_sel_q  <= 1'b0;
      bank_q     <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      rd_cnt_q   <= '0;
      busy_q     <= 1'b0;
      wr_v_q     <= 1'b0;
      wr_lane_q  <= '0;
      wr_idx_q   <= '0;
      fifo_re_q  <= '{default: '0};
      fifo_im_q  <= '{default: '0};
      fifo_idx_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ram_sel_q  <= ram_sel_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      rd_idx_q   <= rd_idx_d;
      rd_cnt_q   <= rd_cnt_d;
      busy_q     <= busy_d;
      wr_v_q     <= wr_v_d;
      wr_lane_q  <= wr_lane_d;
      wr_idx_q   <= wr_idx_d;
      fifo_re_q  <= fifo_re_d;
      fifo_im_q  <= fifo_im_d;
      fifo_idx_q <= fifo_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign oRAM_SEL        = ram_sel_q;
  assign oBANK_SEL       = bank_q;
  assign oADDR_RD        = addr_q;
  assign oRD_EN          = rd_en_q;
  assign oBUSY           = busy_q;
  assign out_if.oVALID   = (fifo_cnt_q != '0);
  assign out_if.oDATA_RE = fifo_re_q[rd_ptr_q];
  assign out_if.oDATA_IM = fifo_im_q[rd_ptr_q];
  assign out_if.oINDEX   = fifo_idx_q[rd_ptr_q];
  assign out_if.oLAST    = out_if.oVALID && (fifo_idx_q[rd_ptr_q] == 11'h7FF);

endmodule

// File: tb/tb_fft_unload.sv
module tb_fft_unload;

  localparam int DATA_W = 16;
  localparam int FIFO_D = 4;

  logic              iCLK = 1'b0;
  logic              iRESET;
  logic              iSTART;
  logic              iSOURCE_DATA;
  logic              oRAM_SEL;
  logic [1:0]        oBANK_SEL;
  logic [8:0]        oADDR_RD;
  logic              oRD_EN;
  logic              oBUSY;
  logic [DATA_W-1:0] rd_re [4];
  logic [DATA_W-1:0] rd_im [4];

  fft_unload_if #(.DATA_W(DATA_W)) bus ();

  fft_unload #(.DATA_W(DATA_W), .FIFO_D(FIFO_D)) dut (
    .iCLK         (iCLK),
    .iRESET       (iRESET),
    .iSTART       (iSTART),
    .iSOURCE_DATA (iSOURCE_DATA),
    .oRAM_SEL     (oRAM_SEL),
    .oBANK_SEL    (oBANK_SEL),
    .oADDR_RD     (oADDR_RD),
    .oRD_EN       (oRD_EN),
    .iRD_RE_0     (rd_re[0]),
    .iRD_RE_1     (rd_re[1]),
    .iRD_RE_2     (rd_re[2]),
    .iRD_RE_3     (rd_re[3]),
    .iRD_IM_0     (rd_im[0]),
    .iRD_IM_1     (rd_im[1]),
    .iRD_IM_2     (rd_im[2]),
    .iRD_IM_3     (rd_im[3]),
    .out_if       (bus),
    .oBUSY        (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // Preload pattern: re = {set, 0000, bank, addr}, im = ~re.
  function automatic logic [15:0] ram_re(input logic set, input logic [1:0] b, input logic [8:0] a);
    return {set, 4'b0000, b, a};
  endfunction

  // Bank RAMs: synchronous read, data on the bus the cycle after the strobe.
  always @(posedge iCLK) begin
    if (oRD_EN === 1'b1) begin
      for (int b = 0; b < 4; b++) begin
        rd_re[b] <= ram_re(oRAM_SEL, 2'(b), oADDR_RD);
        rd_im[b] <= ~ram_re(oRAM_SEL, 2'(b), oADDR_RD);
      end
    end
  end

  // Where bin n is stored.
  function automatic logic [10:0] where_stored(input int n);
    logic [10:0] v;
    v = 11'(n);
`ifdef UNLOAD_DIGIT_REV_EN
    return {v[1:0], v[3:2], v[5:4], v[7:6], v[9:8], v[10]};
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] model_re(input logic set, input int n);
    logic [10:0] s;
    s = where_stored(n);
    return ram_re(set, s[10:9], s[8:0]);
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state, shared with the stimulus between runs.
  int          exp_n;
  logic        exp_set;
  bit          mon_en = 0;
  bit          stalled_prev;
  bit          expect_idle;
  int          issued, popped;
  logic [43:0] prev_word;
  logic [15:0] got_re [2048];
  logic [15:0] got_im [2048];

  task automatic reset_model();
    exp_n        = 0;
    stalled_prev = 0;
    expect_idle  = 0;
    issued       = 0;
    popped       = 0;
  endtask

  always @(negedge iCLK) begin
    if (mon_en && iRESET === 1'b1) begin
      logic [43:0] cur;
      logic [15:0] er;
      cur = {bus.oDATA_RE, bus.oDATA_IM, bus.oINDEX, bus.oLAST};
      if (expect_idle) begin
        chk("busy_drop_after_last", {63'd0, oBUSY}, 64'd0);
        expect_idle = 0;
      end
      if (oRD_EN === 1'b1) issued++;
      if (bus.oVALID === 1'b1) begin
        if (stalled_prev) chk("hold_while_stalled", {20'd0, cur}, {20'd0, prev_word});
        if (exp_n >= 2048) begin
          chk("extra_word_count", 64'(exp_n), 64'd2047);
        end else begin
          er = model_re(exp_set, exp_n);
          chk("word", {20'd0, cur}, {20'd0, er, ~er, 11'(exp_n), (exp_n == 2047)});
          got_re[exp_n] = bus.oDATA_RE;
          got_im[exp_n] = bus.oDATA_IM;
          if (bus.iREADY === 1'b1) begin
            popped++;
            if (exp_n == 2047) begin
              chk("busy_at_last", {63'd0, oBUSY}, 64'd1);
              expect_idle = 1;
            end
            exp_n++;
          end
        end
        stalled_prev = (bus.iREADY !== 1'b1);
        prev_word    = cur;
      end else begin
        if (stalled_prev) chk("valid_drop_while_stalled", {63'd0, bus.oVALID}, 64'd1);
        stalled_prev = 0;
      end
      if (oBUSY === 1'b1) chk("ram_sel", {63'd0, oRAM_SEL}, {63'd0, exp_set});
      chk("occupancy_bound", {63'd0, (issued - popped) <= FIFO_D}, 64'd1);
    end
  end

  bit rdy_random = 0;
  initial begin
    bus.iREADY = 1'b1;
    forever begin
      @(posedge iCLK);
      #1;
      bus.iREADY = rdy_random ? ($urandom_range(0, 99) < 55) : 1'b1;
    end
  end

  task automatic start_unload(input logic set);
    @(posedge iCLK); #1;
    iSTART       = 1'b1;
    iSOURCE_DATA = set;
    @(posedge iCLK); #1;
    iSTART       = 1'b0;
    iSOURCE_DATA = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!(exp_n >= 2048 && oBUSY === 1'b0) && c < budget) begin
      @(negedge iCLK);
      c++;
    end
    chk("words_out", 64'(exp_n), 64'd2048);
    @(negedge iCLK);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    iRESET       = 1'b0;
    iSTART       = 1'b0;
    iSOURCE_DATA = 1'b0;
    reset_model();
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("reset_outputs",
        {20'd0, oRAM_SEL, oBANK_SEL, oADDR_RD, oRD_EN, oBUSY, bus.oVALID, bus.oLAST,
         bus.oINDEX, bus.oDATA_RE},
        64'd0);
    @(posedge iCLK); #1;
    iRESET = 1'b1;
    mon_en = 1;

    // Run 1: set A, iREADY held high, first-word latency.
    exp_set = 1'b0;
    start_unload(1'b0);
    c = 1;
    @(negedge iCLK);
    while (bus.oVALID !== 1'b1 && c < 20) begin
      @(negedge iCLK);
      c++;
    end
    chk("first_word_latency", 64'(c), 64'd3);
    chk("first_word_index", {53'd0, bus.oINDEX}, 64'd0);
    wait_done(5000);
`ifdef UNLOAD_DIGIT_REV_EN
    chk("lit_re_n1",    {48'd0, got_re[1]},    64'h0200);
    chk("lit_re_n512",  {48'd0, got_re[512]},  64'h0004);
    chk("lit_re_n1024", {48'd0, got_re[1024]}, 64'h0001);
`else
    chk("lit_re_k1",    {48'd0, got_re[1]},    64'h0001);
    chk("lit_re_k512",  {48'd0, got_re[512]},  64'h0200);
    chk("lit_re_k1024", {48'd0, got_re[1024]}, 64'h0400);
`endif
    chk("lit_re_0",    {48'd0, got_re[0]},    64'h0000);
    chk("lit_re_2047", {48'd0, got_re[2047]}, 64'h07FF);
    chk("lit_im_2047", {48'd0, got_im[2047]}, 64'hF800);

    // Run 2: set B, random backpressure, ignored second iSTART mid-unload.
    reset_model();
    exp_set    = 1'b1;
    rdy_random = 1;
    start_unload(1'b1);
    c = 0;
    while (exp_n < 1000 && c < 10000) begin
      @(negedge iCLK);
      c++;
    end
    start_unload(1'b0);
    wait_done(20000);
    rdy_random = 0;
`ifdef UNLOAD_DIGIT_REV_EN
    chk("lit_b_re_n5", {48'd0, got_re[5]}, 64'h8280);
`else
    chk("lit_b_re_k5", {48'd0, got_re[5]}, 64'h8005);
`endif
    chk("lit_b_im_2047", {48'd0, got_im[2047]}, 64'h7800);

    // Run 3: asynchronous reset at word 700, then a full restart.
    reset_model();
    exp_set = 1'b0;
    start_unload(1'b0);
    c = 0;
    while (exp_n < 700 && c < 5000) begin
      @(negedge iCLK);
      c++;
    end
    chk("reached_word_700", 64'(exp_n >= 700), 64'd1);
    #2;
    iRESET = 1'b0;
    #1;
    chk("async_reset_outputs", {61'd0, bus.oVALID, oBUSY, oRD_EN}, 64'd0);
    reset_model();
    @(posedge iCLK); #1;
    iRESET = 1'b1;
    start_unload(1'b0);
    c = 1;
    @(negedge iCLK);
    while (bus.oVALID !== 1'b1 && c < 20) begin
      @(negedge iCLK);
      c++;
    end
    chk("restart_latency", 64'(c), 64'd3);
    chk("restart_index", {53'd0, bus.oINDEX}, 64'd0);
    wait_done(5000);
    chk("restart_lit_re_2047", {48'd0, got_re[2047]}, 64'h07FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
